// File: rtl/queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : queue_fifo
// Purpose  : Circular-buffer FIFO with registered read data, occupancy count,
//            full/empty flags and sticky overflow/underflow flags.
//            Optional macro QUEUE_SNAPSHOT_EN adds a dequeue-order debug view.
// Revision : 1.0 - initial release
// ============================================================================
module queue_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
`ifdef QUEUE_SNAPSHOT_EN
   ,
   output logic [DEPTH*WIDTH-1:0] snapshot
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic             w_pop_ok;
   logic             w_push_ok;
   logic [CW-1:0]    w_count_nxt;

   // A full queue still accepts a push when a pop frees the head slot this cycle.
   assign w_pop_ok    = pop && (count != '0);
   assign w_push_ok   = push && ((count != C_DEPTH) || w_pop_ok);
   assign w_count_nxt = count + CW'(w_push_ok) - CW'(w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok && !rst) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            dout     <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         dout_valid <= w_pop_ok;
         count      <= w_count_nxt;
         full       <= (w_count_nxt == C_DEPTH);
         empty      <= (w_count_nxt == '0);
         if (push && !w_push_ok) begin
            overflow <= 1'b1;
         end
         if (pop && !w_pop_ok) begin
            underflow <= 1'b1;
         end
      end
   end

`ifdef QUEUE_SNAPSHOT_EN
   // Slot k shows the k-th word to be dequeued; unused slots read as zero.
   for (genvar k = 0; k < DEPTH; k++) begin : g_snap
      logic [AW-1:0] w_idx;
      assign w_idx = r_rd_ptr + AW'(k);
      assign snapshot[k*WIDTH +: WIDTH] = (CW'(k) < count) ? r_mem[w_idx] : '0;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_fifo
// Purpose  : Directed self-checking bench for queue_fifo using a reference
//            queue model and an expected-read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_fifo;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;
`ifdef QUEUE_SNAPSHOT_EN
   logic [DEPTH*WIDTH-1:0] snapshot;
`endif

   queue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
      .underflow  (underflow)
`ifdef QUEUE_SNAPSHOT_EN
      ,
      .snapshot   (snapshot)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned      vectors     = 0;
   int unsigned      miscompares = 0;
   logic [WIDTH-1:0] model [$];
   logic [WIDTH-1:0] sb    [$];
   logic [WIDTH-1:0] m_dout;
   logic             m_ovf;
   logic             m_unf;
   logic             m_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      logic [31:0] snap_exp;
      check("dout_valid", 32'(dout_valid), 32'(m_valid));
      if (dout_valid) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed dout_valid=1 expected no pending read");
         end else begin
            m_dout = sb.pop_front();
         end
      end
      check("dout", 32'(dout), 32'(m_dout));
      check("count", 32'(count), 32'(model.size()));
      check("full", 32'(full), 32'(model.size() == DEPTH));
      check("empty", 32'(empty), 32'(model.size() == 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
`ifdef QUEUE_SNAPSHOT_EN
      snap_exp = '0;
      for (int k = 0; k < model.size(); k++) snap_exp[k*WIDTH +: WIDTH] = model[k];
      check("snapshot", 32'(snapshot), snap_exp);
`endif
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
      repeat (cycles) @(posedge clk);
      #1;
      model.delete(); sb.delete();
      m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
      check_state();
      rst = 1'b0;
   endtask

   // One clock of stimulus; the model and scoreboard advance on the same edge.
   task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
      logic pop_ok, push_ok;
      pop_ok  = q && (model.size() != 0);
      push_ok = p && ((model.size() != DEPTH) || pop_ok);
      if (pop_ok) sb.push_back(model.pop_front());
      if (push_ok) model.push_back(d);
      if (p && !push_ok) m_ovf = 1'b1;
      if (q && !pop_ok) m_unf = 1'b1;
      m_valid = pop_ok;
      push = p; pop = q; din = d;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0;
      check_state();
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;

      // Reset then idle
      do_reset(2);
      step(0, 0, 0);

      // Fill and drain
      for (int i = 1; i <= 4; i++) step(1, 0, 4'(i));
      check("full_after_fill", 32'(full), 32'd1);
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      check("empty_after_drain", 32'(empty), 32'd1);
      check("last_drain_dout", 32'(dout), 32'h4);

      // Overflow then underflow
      for (int i = 1; i <= 4; i++) step(1, 0, 4'(i));
      step(1, 0, 4'hF);
      check("overflow_set", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      step(0, 1, 0);
      check("underflow_set", 32'(underflow), 32'd1);
      check("dout_hold", 32'(dout), 32'h4);

      // Simultaneous push/pop at full and at empty
      do_reset(1);
      for (int i = 1; i <= 4; i++) step(1, 0, 4'(i));
      step(1, 1, 4'h5);
      check("pp_full_dout", 32'(dout), 32'h1);
      check("pp_full_no_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      step(1, 1, 4'h9);
      check("pp_empty_count", 32'(count), 32'd1);
      step(0, 1, 0);
      check("pp_empty_dout", 32'(dout), 32'h9);

      // Wrap-around with two entries resident
      do_reset(1);
      step(1, 0, 4'h0);
      step(1, 0, 4'h1);
      for (int i = 2; i <= 9; i++) step(1, 1, 4'(i));
      step(0, 1, 0);
      step(0, 1, 0);
      check("wrap_last_dout", 32'(dout), 32'h9);

      // Mid-operation reset, then snapshot view
      for (int i = 1; i <= 3; i++) step(1, 0, 4'(i));
      do_reset(1);
      step(0, 1, 0);
      check("post_reset_underflow", 32'(underflow), 32'd1);
      step(1, 0, 4'hA);
      step(1, 0, 4'hB);
`ifdef QUEUE_SNAPSHOT_EN
      check("snapshot_BA", 32'(snapshot), 32'h00BA);
`endif
      step(0, 0, 0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
